// File: rtl/demux5_out_if.sv
// rtl/demux5_out_if.sv - producer/consumer bundle for the 1-to-5 registered demultiplexer
//
// Signals:
//   Order     [2:0]  destination select, 0..4 valid, 5..7 illegal (beat discarded)
//   DataIn    [31:0] payload to route
//   InValid          producer has a beat
//   InReady          demux accepts the beat this cycle
//   DataOut0..4      registered payload per destination
//   OutValid  [4:0]  bit k: DataOutk holds an unconsumed beat
//   OutReady  [4:0]  bit k: destination k consumes this cycle
//   ErrFlag          sticky illegal-Order indicator
//   ErrOrder  [2:0]  Order of the first illegal beat
// Modports: slave = the demux, master = producer/consumers driving it.
interface demux5_out_if;
  logic [2:0]  Order;
  logic [31:0] DataIn;
  logic        InValid;
  logic        InReady;
  logic [31:0] DataOut0;
  logic [31:0] DataOut1;
  logic [31:0] DataOut2;
  logic [31:0] DataOut3;
  logic [31:0] DataOut4;
  logic [4:0]  OutValid;
  logic [4:0]  OutReady;
  logic        ErrFlag;
  logic [2:0]  ErrOrder;

  modport slave (
    input  Order, DataIn, InValid, OutReady,
    output InReady, DataOut0, DataOut1, DataOut2, DataOut3, DataOut4,
           OutValid, ErrFlag, ErrOrder
  );

  modport master (
    output Order, DataIn, InValid, OutReady,
    input  InReady, DataOut0, DataOut1, DataOut2, DataOut3, DataOut4,
           OutValid, ErrFlag, ErrOrder
  );
endinterface

// File: rtl/demux5_out.sv
// rtl/demux5_out.sv - 1-to-5 demultiplexer with a one-entry registered slot per destination
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset; empties all slots, clears data and error state
//   bus    demux5_out_if.slave (see interface file for the signal list)
// Optional feature: define DEMUX5_ERR_EN to build the sticky ErrFlag/ErrOrder capture
// of the first illegal Order; otherwise both outputs are tied to zero.
module demux5_out (
  input  logic         clk,
  input  logic         rst_n,
  demux5_out_if.slave  bus
);

  logic [4:0][31:0] r_data;
  logic [4:0]       r_valid;

  logic [4:0] w_sel;
  logic       w_legal;
  logic       w_in_ready;
  logic       w_fire;
  logic [4:0] w_fill;

  // One-hot decode of Order; all zero for illegal values.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < 5; k++) begin
      w_sel[k] = (bus.Order == 3'(k));
    end
  end

  assign w_legal = (bus.Order <= 3'd4);

  // Illegal beats are always accepted (and dropped). A legal beat is accepted
  // when its slot is empty or is being drained on this same edge.
  assign w_in_ready = ~w_legal | (|(w_sel & (~r_valid | bus.OutReady)));
  assign w_fire     = bus.InValid & w_in_ready;
  assign w_fill     = w_fire ? w_sel : 5'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        // Fill wins over drain so a same-edge drain+fill keeps the slot full.
        if (w_fill[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= bus.DataIn;
        end else if (bus.OutReady[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX5_ERR_EN
  logic       r_err_flag;
  logic [2:0] r_err_order;

  // Only the first illegal beat after reset is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag  <= 1'b0;
      r_err_order <= 3'b000;
    end else if (w_fire && !w_legal && !r_err_flag) begin
      r_err_flag  <= 1'b1;
      r_err_order <= bus.Order;
    end
  end

  assign bus.ErrFlag  = r_err_flag;
  assign bus.ErrOrder = r_err_order;
`else
  assign bus.ErrFlag  = 1'b0;
  assign bus.ErrOrder = 3'b000;
`endif

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = r_valid;
  assign bus.DataOut0 = r_data[0];
  assign bus.DataOut1 = r_data[1];
  assign bus.DataOut2 = r_data[2];
  assign bus.DataOut3 = r_data[3];
  assign bus.DataOut4 = r_data[4];

endmodule
